dmem_resp: RTL and testbench
============================

DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, number of wait-state cycles between request acceptance and ack (legal 0-15).
REQ-002 Parameter DEPTH, default 256, number of 16-bit words in the backing store; only addr[7:0] indexes it.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  1  initiator request; held high with addr/we/wdata stable until ack is seen.
REQ-006 we  input  1  1 = store, 0 = load; sampled with req.
REQ-007 addr  input  16  word address; bits [15:8] ignored (wrap).
REQ-008 wdata  input  16  store data; sampled with req.
REQ-009 ack  output  1  one-cycle completion pulse.
REQ-010 rdata  output  16  load data; valid in the ack cycle of a load.
REQ-011 busy  output  1  high while a request is in flight (WAIT or ACK state).

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, WAIT, ACK.
REQ-013 In IDLE with req=1, the block SHALL latch we, addr[7:0] and wdata on that edge and go to WAIT, or to ACK if WAIT_CYCLES=0.
REQ-014 In IDLE with req=0, the block SHALL stay in IDLE, leaving all state unchanged.
REQ-015 On entering WAIT, a 4-bit counter SHALL load WAIT_CYCLES-1 and decrement each cycle; at zero the FSM SHALL go to ACK.
REQ-016 Total latency: ack SHALL assert exactly WAIT_CYCLES+1 cycles after the accepting edge (the cycle after acceptance when WAIT_CYCLES=0).
REQ-017 In ACK, ack SHALL be 1 for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-018 req sampled high during WAIT or ACK SHALL be ignored; a held req after ack SHALL be accepted as a new request in IDLE (min 2-cycle spacing between accepts).
REQ-019 Load: rdata SHALL be driven from the latched address in the ack cycle and SHALL hold that value until the next load ack.
REQ-020 Store: the memory write of the latched wdata SHALL commit on the rising edge that ends the ACK cycle; rdata SHALL remain unchanged.
REQ-021 A load to an address immediately following a store to the same address SHALL return the stored value.
REQ-022 Inputs changing during WAIT/ACK SHALL NOT affect the in-flight transaction (latched copies only).
REQ-023 busy SHALL equal (state != IDLE).

Reset
REQ-024 While rst_n=0: state=IDLE, counter=0, ack=0, busy=0, rdata=16'h0000, and latched request registers=0.
REQ-025 Reset asserted mid-transaction SHALL abort it; a pending store SHALL NOT be written, and no ack SHALL be issued afterwards.
REQ-026 Memory array contents are not reset; values are undefined until written.
REQ-027 After rst_n deasserts, a req high on the first rising edge SHALL be accepted normally.

Verification
REQ-028 Store 16'hBEEF to addr 16'h0010, then load 16'h0010 (WAIT_CYCLES=2) -> each ack exactly 3 cycles after accept; load rdata=16'hBEEF.
REQ-029 WAIT_CYCLES=0: load after store 16'h1234 to addr 16'h00FF -> ack 1 cycle after accept; rdata=16'h1234.
REQ-030 Store 16'hA5A5 to addr 16'h0105, load addr 16'h0005 -> rdata=16'hA5A5 (upper-bit wrap).
REQ-031 req held high continuously for 3 loads -> acks every 4 cycles (WAIT_CYCLES=2); busy low exactly one cycle between them.
REQ-032 Store 16'h5555 to addr 3; start store 16'hFFFF to addr 3, pull rst_n low in WAIT -> no ack; after reset, load addr 3 -> rdata=16'h5555.
REQ-033 Change addr/wdata/we during WAIT of a load from addr 7 (holding 16'h0042) -> rdata=16'h0042; memory unchanged.

Source files
------------

// File: rtl/dmem_resp.sv
// Wait-stated 16-bit data memory responder: one request in flight, IDLE -> WAIT -> ACK.
// Loads present rdata in the ack cycle; stores commit on the edge that closes ACK.
module dmem_resp #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH       = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic       NO_WAIT   = (WAIT_CYCLES == 0);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [3:0]  cnt;
    logic        accept;

    logic        we_p0;
    logic [7:0]  addr_p0;
    logic [15:0] wdata_p0;

    logic        rd_en;
    logic [7:0]  rd_addr;

    logic [15:0] mem [DEPTH];

    // Upper address bits are deliberately ignored; the store wraps every 256 words.
    logic        unused_addr_hi;
    assign unused_addr_hi = ^addr[15:8];

    assign accept = (state == S_IDLE) && req;
    assign ack    = (state == S_ACK);
    assign busy   = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req) state_nxt = NO_WAIT ? S_ACK : S_WAIT;
            S_WAIT:  if (cnt == 4'd0) state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The read fires on the edge entering ACK; with no wait states that is the
    // accepting edge itself, so the live inputs are used instead of the latches.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = addr_p0;
        if (NO_WAIT && accept) begin
            rd_en   = !we;
            rd_addr = addr[7:0];
        end else if ((state == S_WAIT) && (cnt == 4'd0)) begin
            rd_en   = !we_p0;
            rd_addr = addr_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= WAIT_LOAD;
            end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // ---- request capture stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_p0    <= 1'b0;
            addr_p0  <= 8'h00;
            wdata_p0 <= 16'h0000;
        end else if (accept) begin
            we_p0    <= we;
            addr_p0  <= addr[7:0];
            wdata_p0 <= wdata;
        end
    end

    // ---- response stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 16'h0000;
        end else if (rd_en) begin
            rdata <= mem[rd_addr];
        end
    end

    // Array has no reset; an aborted transaction never reaches ACK, so it never writes.
    always_ff @(posedge clk) begin
        if ((state == S_ACK) && we_p0) begin
            mem[addr_p0] <= wdata_p0;
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: one instance with two wait states, one with none.
module tb_dmem_resp;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  ack;
    logic [1:0]  busy;
    logic [15:0] addr  [2];
    logic [15:0] wdata [2];
    logic [15:0] rdata [2];

    int n_pass;
    int n_total;

    dmem_resp #(.WAIT_CYCLES(2), .DEPTH(256)) u_w2 (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]), .addr(addr[0]),
        .wdata(wdata[0]), .ack(ack[0]), .rdata(rdata[0]), .busy(busy[0])
    );

    dmem_resp #(.WAIT_CYCLES(0), .DEPTH(256)) u_w0 (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]), .addr(addr[1]),
        .wdata(wdata[1]), .ack(ack[1]), .rdata(rdata[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one request at a falling edge; lat = cycles from accepting edge to ack.
    task automatic xact(input int d, input logic w, input logic [15:0] a,
                        input logic [15:0] wd, output int lat, output logic [15:0] rd);
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        lat = 99;
        rd  = 16'hxxxx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ack[d]) begin
                lat = k;
                rd  = rdata[d];
                break;
            end
        end
        req[d] = 1'b0; we[d] = 1'b0;
    endtask

    initial begin
        int lat;
        logic [15:0] rd;
        logic saw_ack;

        n_pass = 0; n_total = 0;
        rst_n = 1'b0; req = 2'b00; we = 2'b00;
        addr[0] = 16'h0; addr[1] = 16'h0; wdata[0] = 16'h0; wdata[1] = 16'h0;
        repeat (2) @(negedge clk);
        chk("rst_ack_w2",   16'(ack[0]),  16'h0);
        chk("rst_busy_w2",  16'(busy[0]), 16'h0);
        chk("rst_rdata_w2", rdata[0],     16'h0000);
        chk("rst_rdata_w0", rdata[1],     16'h0000);
        rst_n = 1'b1;

        // Store then load, two wait states
        xact(0, 1'b1, 16'h0010, 16'hBEEF, lat, rd);
        chk("st_lat_w2", 16'(lat), 16'd3);
        chk("st_rdata_unchanged", rdata[0], 16'h0000);
        xact(0, 1'b0, 16'h0010, 16'h0000, lat, rd);
        chk("ld_lat_w2", 16'(lat), 16'd3);
        chk("ld_data_beef", rd, 16'hBEEF);
        @(negedge clk);
        chk("ld_data_hold", rdata[0], 16'hBEEF);

        // No wait states
        xact(1, 1'b1, 16'h00FF, 16'h1234, lat, rd);
        chk("st_lat_w0", 16'(lat), 16'd1);
        xact(1, 1'b0, 16'h00FF, 16'h0000, lat, rd);
        chk("ld_lat_w0", 16'(lat), 16'd1);
        chk("ld_data_w0", rd, 16'h1234);

        // Upper address bits wrap
        xact(0, 1'b1, 16'h0105, 16'hA5A5, lat, rd);
        xact(0, 1'b0, 16'h0005, 16'h0000, lat, rd);
        chk("wrap_data", rd, 16'hA5A5);
        chk("wrap_lat", 16'(lat), 16'd3);

        // Back-to-back loads with req held: ack at 3,7,11; busy low at 4,8,12
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0010;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("held_ack_c%0d", k), 16'(ack[0]), 16'((k % 4) == 3));
            chk($sformatf("held_busy_c%0d", k), 16'(busy[0]), 16'((k % 4) != 0));
        end
        chk("held_rdata", rdata[0], 16'hBEEF);
        req[0] = 1'b0;
        @(negedge clk);

        // Reset in WAIT aborts a pending store
        xact(0, 1'b1, 16'h0003, 16'h5555, lat, rd);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0003; wdata[0] = 16'hFFFF;
        @(negedge clk);
        chk("abort_busy_in_wait", 16'(busy[0]), 16'h1);
        rst_n = 1'b0;
        req[0] = 1'b0; we[0] = 1'b0;
        #1;
        chk("abort_busy_rst", 16'(busy[0]), 16'h0);
        chk("abort_rdata_rst", rdata[0], 16'h0000);
        saw_ack = 1'b0;
        repeat (2) begin
            @(negedge clk);
            saw_ack = saw_ack | ack[0];
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            saw_ack = saw_ack | ack[0];
        end
        chk("abort_no_ack", 16'(saw_ack), 16'h0);
        xact(0, 1'b0, 16'h0003, 16'h0000, lat, rd);
        chk("abort_mem_kept", rd, 16'h5555);

        // Request present on the first edge after reset release is accepted
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0010;
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ack[0]) begin
                lat = k;
                break;
            end
        end
        req[0] = 1'b0;
        chk("post_rst_lat", 16'(lat), 16'd3);
        chk("post_rst_data", rdata[0], 16'hBEEF);

        // Inputs changing mid-flight do not disturb a load
        xact(0, 1'b1, 16'h0007, 16'h0042, lat, rd);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0007; wdata[0] = 16'h0000;
        @(negedge clk);
        we[0] = 1'b1; addr[0] = 16'h0010; wdata[0] = 16'hFFFF;
        lat = 99;
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk);
            if (ack[0]) begin
                lat = k;
                break;
            end
        end
        req[0] = 1'b0; we[0] = 1'b0;
        chk("midflight_lat", 16'(lat), 16'd3);
        chk("midflight_data", rdata[0], 16'h0042);
        xact(0, 1'b0, 16'h0010, 16'h0000, lat, rd);
        chk("midflight_mem10", rd, 16'hBEEF);
        xact(0, 1'b0, 16'h0007, 16'h0000, lat, rd);
        chk("midflight_mem7", rd, 16'h0042);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
